mem_bus_arbiter: RTL and testbench

Two-master memory bus arbiter directly downstream of the CPU load/store unit. It merges the data port (load/store unit: addr/data/bytesel/wr_en/access/ack) and the read-only instruction-fetch port onto the single memory bus toward the memory controller. Data has fixed priority, with a starvation limit that guarantees instruction fetch progress. Transfers are non-preemptive and every bus output is registered.

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/mem_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the memory bus arbiter
package mem_bus_pkg;

   // Arbiter sequencing: sample requests, own the bus, then a one-cycle gap
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_D = 2'd1,
      GRANT_I = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   // Word address occupies bits [19:1]; byte lanes are selected by bytesel
   localparam int MEM_ADDR_W = 19;
   localparam int MEM_DATA_W = 16;
   localparam int MEM_BSEL_W = 2;

   localparam logic OWNER_DATA  = 1'b1;
   localparam logic OWNER_FETCH = 1'b0;

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master (data/fetch) memory bus arbiter with starvation limit
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic [MEM_ADDR_W:1]   d_m_addr,
   input  logic [MEM_DATA_W-1:0] d_m_data_out,
   output logic [MEM_DATA_W-1:0] d_m_data_in,
   input  logic                  d_m_access,
   input  logic                  d_m_wr_en,
   input  logic [MEM_BSEL_W-1:0] d_m_bytesel,
   output logic                  d_m_ack,

   input  logic [MEM_ADDR_W:1]   i_m_addr,
   input  logic                  i_m_access,
   output logic [MEM_DATA_W-1:0] i_m_data_in,
   output logic                  i_m_ack,

   output logic [MEM_ADDR_W:1]   q_m_addr,
   output logic [MEM_DATA_W-1:0] q_m_data_out,
   input  logic [MEM_DATA_W-1:0] q_m_data_in,
   output logic                  q_m_access,
   output logic                  q_m_wr_en,
   output logic [MEM_BSEL_W-1:0] q_m_bytesel,
   input  logic                  q_m_ack,
   output logic                  q_owner
);

   // Streak is 4 bits wide, so the limit is compared in that width
   localparam logic [3:0] STREAK_LIMIT = 4'(STARVE_LIMIT);

   arb_state_t state;
   arb_state_t state_nxt;
   logic [3:0] streak;
   logic       fetch_starved;
   logic       grant_d;
   logic       grant_i;
   logic       xfer_done;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: grants only from IDLE, completion only while owning the bus
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_d) begin
               state_nxt = GRANT_D;
            end else if (grant_i) begin
               state_nxt = GRANT_I;
            end
         end
         GRANT_D,
         GRANT_I: begin
            if (q_m_ack) begin
               state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Grant/complete decode; data wins unless fetch has waited out the streak
   always_comb begin
      fetch_starved = i_m_access && (streak == STREAK_LIMIT);
      grant_d       = (state == IDLE) && d_m_access && !fetch_starved;
      grant_i       = (state == IDLE) && i_m_access && !grant_d;
      xfer_done     = ((state == GRANT_D) || (state == GRANT_I)) && q_m_ack;
   end

   // Count consecutive data grants taken while fetch was kept waiting
   always_ff @(posedge clk) begin
      if (!reset) begin
         streak <= 4'd0;
      end else if (grant_d) begin
         if (!i_m_access) begin
            streak <= 4'd0;
         end else if (streak != STREAK_LIMIT) begin
            streak <= streak + 4'd1;
         end
      end else if (grant_i) begin
         streak <= 4'd0;
      end
   end

   // Registered bus and port outputs: latch on grant, hold, clear on completion
   always_ff @(posedge clk) begin
      if (!reset) begin
         q_m_addr     <= '0;
         q_m_data_out <= '0;
         q_m_access   <= 1'b0;
         q_m_wr_en    <= 1'b0;
         q_m_bytesel  <= '0;
         q_owner      <= OWNER_FETCH;
         d_m_data_in  <= '0;
         i_m_data_in  <= '0;
         d_m_ack      <= 1'b0;
         i_m_ack      <= 1'b0;
      end else begin
         d_m_ack <= 1'b0;
         i_m_ack <= 1'b0;
         if (grant_d) begin
            q_m_addr     <= d_m_addr;
            q_m_data_out <= d_m_data_out;
            q_m_wr_en    <= d_m_wr_en;
            q_m_bytesel  <= d_m_bytesel;
            q_m_access   <= 1'b1;
            q_owner      <= OWNER_DATA;
         end else if (grant_i) begin
            q_m_addr     <= i_m_addr;
            q_m_data_out <= '0;
            q_m_wr_en    <= 1'b0;
            q_m_bytesel  <= 2'b11;
            q_m_access   <= 1'b1;
            q_owner      <= OWNER_FETCH;
         end else if (xfer_done) begin
            q_m_addr     <= '0;
            q_m_data_out <= '0;
            q_m_wr_en    <= 1'b0;
            q_m_bytesel  <= '0;
            q_m_access   <= 1'b0;
            // Read data is returned to the owner even for writes
            if (state == GRANT_D) begin
               d_m_data_in <= q_m_data_in;
               d_m_ack     <= 1'b1;
            end else begin
               i_m_data_in <= q_m_data_in;
               i_m_ack     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   typedef struct packed {
      logic        owner;
      logic [19:1] addr;
      logic        wr;
      logic [1:0]  bsel;
      logic [15:0] wdata;
   } grant_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:1] d_m_addr;
   logic [15:0] d_m_data_out;
   logic [15:0] d_m_data_in;
   logic        d_m_access;
   logic        d_m_wr_en;
   logic [1:0]  d_m_bytesel;
   logic        d_m_ack;
   logic [19:1] i_m_addr;
   logic        i_m_access;
   logic [15:0] i_m_data_in;
   logic        i_m_ack;
   logic [19:1] q_m_addr;
   logic [15:0] q_m_data_out;
   logic [15:0] q_m_data_in;
   logic        q_m_access;
   logic        q_m_wr_en;
   logic [1:0]  q_m_bytesel;
   logic        q_m_ack;
   logic        q_owner;

   int checks = 0;
   int errors = 0;
   int d_acks = 0;
   int i_acks = 0;
   int exp_d  = 0;
   int exp_i  = 0;
   int slave_wait = 0;
   int scnt = 0;
   logic noise_ack = 1'b0;
   logic prev_acc = 1'b0;
   logic prev_d_ack = 1'b0;
   logic prev_i_ack = 1'b0;
   logic [19:1] last_d_addr = '0;
   logic [19:1] last_i_addr = '0;
   grant_t cur;
   grant_t exp_q[$];

   mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .d_m_addr(d_m_addr), .d_m_data_out(d_m_data_out), .d_m_data_in(d_m_data_in),
      .d_m_access(d_m_access), .d_m_wr_en(d_m_wr_en), .d_m_bytesel(d_m_bytesel),
      .d_m_ack(d_m_ack),
      .i_m_addr(i_m_addr), .i_m_access(i_m_access), .i_m_data_in(i_m_data_in),
      .i_m_ack(i_m_ack),
      .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_data_in(q_m_data_in),
      .q_m_access(q_m_access), .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel),
      .q_m_ack(q_m_ack), .q_owner(q_owner)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rdata_of(input logic [19:1] a);
      return a[16:1] ^ 16'hACDB;
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic push_d(input logic [19:1] a, input logic [15:0] wd, input logic [1:0] bs,
                         input logic wr);
      grant_t g;
      g.owner = OWNER_DATA; g.addr = a; g.wr = wr; g.bsel = bs; g.wdata = wr ? wd : 16'h0;
      if (!wr) g.wdata = wd;
      exp_q.push_back(g);
      exp_d++;
   endtask

   task automatic push_i(input logic [19:1] a);
      grant_t g;
      g.owner = OWNER_FETCH; g.addr = a; g.wr = 1'b0; g.bsel = 2'b11; g.wdata = 16'h0;
      exp_q.push_back(g);
      exp_i++;
   endtask

   // Called at a negedge; returns one negedge after the ack with access dropped
   task automatic d_xfer(input logic [19:1] a, input logic [15:0] wd, input logic [1:0] bs,
                         input logic wr, output int lat);
      d_m_addr = a; d_m_data_out = wd; d_m_bytesel = bs; d_m_wr_en = wr;
      d_m_access = 1'b1;
      lat = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         lat++;
         if (d_m_ack) break;
      end
      if (!d_m_ack) check("d_timeout", 0, 1);
      d_m_access = 1'b0;
      @(negedge clk);
   endtask

   task automatic i_xfer(input logic [19:1] a, output int lat);
      i_m_addr = a;
      i_m_access = 1'b1;
      lat = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         lat++;
         if (i_m_ack) break;
      end
      if (!i_m_ack) check("i_timeout", 0, 1);
      i_m_access = 1'b0;
      @(negedge clk);
   endtask

   // Memory slave: acks after slave_wait extra cycles; optional stray ack while idle
   always @(negedge clk) begin
      if (!q_m_access || !reset) begin
         scnt = 0;
         q_m_ack = noise_ack && reset;
      end else if (scnt == slave_wait) begin
         q_m_ack = 1'b1;
         q_m_data_in = rdata_of(q_m_addr);
      end else begin
         q_m_ack = 1'b0;
         scnt++;
      end
   end

   // Bus and port monitor against the scoreboard
   always @(negedge clk) begin
      if (reset) begin
         if (q_m_access && !prev_acc) begin
            if (exp_q.size() == 0) begin
               check("unexpected_grant", 1, 0);
            end else begin
               cur = exp_q.pop_front();
               check("grant", {q_owner, q_m_addr, q_m_wr_en, q_m_bytesel, q_m_data_out}, cur);
               if (cur.owner == OWNER_DATA) last_d_addr = cur.addr;
               else last_i_addr = cur.addr;
            end
         end else if (q_m_access) begin
            check("bus_stable", {q_owner, q_m_addr, q_m_wr_en, q_m_bytesel, q_m_data_out}, cur);
         end
         if (d_m_ack) begin
            d_acks++;
            check("d_ack_single", prev_d_ack, 0);
            check("d_rdata", d_m_data_in, rdata_of(last_d_addr));
            check("d_bus_cleared", {q_m_access, q_m_wr_en, q_m_addr, q_m_data_out, q_m_bytesel}, 0);
         end
         if (i_m_ack) begin
            i_acks++;
            check("i_ack_single", prev_i_ack, 0);
            check("i_rdata", i_m_data_in, rdata_of(last_i_addr));
            check("i_bus_cleared", {q_m_access, q_m_wr_en, q_m_addr, q_m_data_out, q_m_bytesel}, 0);
         end
      end
      prev_acc   = q_m_access;
      prev_d_ack = d_m_ack;
      prev_i_ack = i_m_ack;
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat_d;
      int lat_i;
      reset = 1'b0;
      d_m_addr = '0; d_m_data_out = '0; d_m_access = 1'b0; d_m_wr_en = 1'b0;
      d_m_bytesel = '0; i_m_addr = '0; i_m_access = 1'b0;
      q_m_data_in = '0; q_m_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_bus", {q_m_access, q_m_wr_en, q_m_addr, q_m_data_out, q_m_bytesel, q_owner}, 0);
      check("rst_ports", {d_m_ack, i_m_ack, d_m_data_in, i_m_data_in}, 0);
      reset = 1'b1;
      @(negedge clk);

      // Fetch-only, zero-wait slave
      slave_wait = 0;
      push_i(19'h01234);
      i_xfer(19'h01234, lat_i);
      check("fetch_latency", lat_i, 2);
      check("fetch_data", i_m_data_in, 16'hBEEF);

      // Data write with a 3-cycle wait
      slave_wait = 3;
      push_d(19'h00100, 16'hA55A, 2'b01, 1'b1);
      d_xfer(19'h00100, 16'hA55A, 2'b01, 1'b1, lat_d);
      check("write_latency", lat_d, 5);
      check("fetch_data_held", i_m_data_in, 16'hBEEF);

      // Simultaneous requests: data first, fetch after RELEASE
      slave_wait = 0;
      push_d(19'h00200, 16'h0000, 2'b11, 1'b0);
      push_i(19'h00300);
      fork
         d_xfer(19'h00200, 16'h0000, 2'b11, 1'b0, lat_d);
         i_xfer(19'h00300, lat_i);
      join
      check("both_d_latency", lat_d, 2);
      check("both_i_latency", lat_i, 5);

      // Starvation: D,D,D,D,I then the waiting data request
      for (int k = 0; k < 4; k++) push_d(19'h00400 + 19'(k), 16'h1000 + 16'(k), 2'b10, 1'b1);
      push_i(19'h00500);
      push_d(19'h00404, 16'h1004, 2'b10, 1'b1);
      fork
         i_xfer(19'h00500, lat_i);
         begin
            for (int k = 0; k < 5; k++)
               d_xfer(19'h00400 + 19'(k), 16'h1000 + 16'(k), 2'b10, 1'b1, lat_d);
         end
      join

      // Back-to-back data at addr, addr+1 with fetch waiting and stray idle acks
      slave_wait = 1;
      noise_ack = 1'b1;
      push_d(19'h00600, 16'h0000, 2'b11, 1'b0);
      push_d(19'h00601, 16'h0000, 2'b11, 1'b0);
      push_i(19'h00700);
      fork
         i_xfer(19'h00700, lat_i);
         begin
            d_xfer(19'h00600, 16'h0000, 2'b11, 1'b0, lat_d);
            d_xfer(19'h00601, 16'h0000, 2'b11, 1'b0, lat_d);
         end
      join
      noise_ack = 1'b0;
      @(negedge clk);

      // Reset while GRANT_D: transfer abandoned, no ack
      slave_wait = 10;
      begin
         grant_t g;
         g.owner = OWNER_DATA; g.addr = 19'h00800; g.wr = 1'b1; g.bsel = 2'b11;
         g.wdata = 16'h7777;
         exp_q.push_back(g);
      end
      d_m_addr = 19'h00800; d_m_data_out = 16'h7777; d_m_bytesel = 2'b11; d_m_wr_en = 1'b1;
      d_m_access = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (q_m_access) break;
      end
      check("rst_test_granted", q_m_access, 1);
      @(negedge clk);
      reset = 1'b0;
      d_m_access = 1'b0;
      @(negedge clk);
      check("midrst_bus", {q_m_access, q_m_wr_en, q_m_addr, q_m_data_out, q_m_bytesel, q_owner}, 0);
      check("midrst_ports", {d_m_ack, d_m_data_in, i_m_data_in}, 0);
      @(negedge clk);
      reset = 1'b1;
      slave_wait = 0;
      repeat (2) @(negedge clk);
      check("midrst_no_ack", d_m_ack, 0);
      push_d(19'h00900, 16'h0000, 2'b11, 1'b0);
      d_xfer(19'h00900, 16'h0000, 2'b11, 1'b0, lat_d);
      check("post_rst_latency", lat_d, 2);
      repeat (3) @(negedge clk);

      check("d_ack_count", d_acks, exp_d);
      check("i_ack_count", i_acks, exp_i);
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
